wb_xbar_decoder: RTL and testbench

WB_XBAR_DECODER -- requirements
Module: wb_xbar_decoder

---
 rtl/wb_xbar_decoder_if.sv | 45 ++++
 rtl/wb_xbar_decoder.sv | 191 +++++++++++++++++++
 tb/tb_wb_xbar_decoder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_xbar_decoder_if.sv
// Wishbone crossbar decoder bus bundle: upstream master port, shared slave
// fan-out, per-slave return paths and the sticky shutdown request.
// slave  modport: the decoder's view.
// master modport: the surrounding system (master + slaves) view.
interface wb_xbar_decoder_if #(
  parameter int NUM_SLAVES = 4
);
  // upstream master
  logic                    i_wb_stb;
  logic                    i_wb_we;
  logic [31:0]             i_wb_addr;
  logic [31:0]             i_wb_data;
  logic [2:0]              i_wb_sel;
  logic [31:0]             o_wb_data;
  logic                    o_wb_ack;
  logic                    o_wb_err;
  logic                    o_wb_stall;
  // downstream slaves
  logic [NUM_SLAVES-1:0]    o_s_wb_stb;
  logic                     o_s_wb_we;
  logic [31:0]              o_s_wb_addr;
  logic [31:0]              o_s_wb_data;
  logic [2:0]               o_s_wb_sel;
  logic [NUM_SLAVES*32-1:0] i_s_wb_data;
  logic [NUM_SLAVES-1:0]    i_s_wb_ack;
  logic [NUM_SLAVES-1:0]    i_s_wb_stall;
  // control
  logic                     o_shutdown;

  modport slave (
    input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_data, o_wb_ack, o_wb_err, o_wb_stall,
    output o_s_wb_stb, o_s_wb_we, o_s_wb_addr, o_s_wb_data, o_s_wb_sel,
    input  i_s_wb_data, i_s_wb_ack, i_s_wb_stall,
    output o_shutdown
  );

  modport master (
    output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_data, o_wb_ack, o_wb_err, o_wb_stall,
    input  o_s_wb_stb, o_s_wb_we, o_s_wb_addr, o_s_wb_data, o_s_wb_sel,
    output i_s_wb_data, i_s_wb_ack, i_s_wb_stall,
    input  o_shutdown
  );
endinterface

// File: rtl/wb_xbar_decoder.sv
// Wishbone 1-to-N address decoder with one outstanding transaction.
// Address-matched slaves see a one-hot strobe; their ack/data pass back
// combinationally. The shutdown register and unmapped addresses are answered
// locally one cycle after the strobe (error for unmapped).
// Optional build macro WB_XBAR_TIMEOUT_EN: adds a wait-cycle counter that
// terminates a silent slave with an error ack after TIMEOUT_CYCLES cycles.

// Per-slave address match: (addr & MASK) == BASE.
module wb_xbar_hit #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] addr,
  output logic        hit
);
  assign hit = ((addr & MASK) == BASE);
endmodule

module wb_xbar_decoder #(
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {32'h2000_0000, 32'hFFFF_FFF1,
                                                          32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {32'hFF00_0000, 32'hFFFF_FFFF,
                                                          32'hFFFF_F000, 32'hFFFF_0000},
  parameter logic [31:0]                SHUTDOWN_ADDR  = 32'hFFFF_FFF2,
  parameter int                         TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  wb_xbar_decoder_if.slave     bus
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Reject illegal configurations at elaboration.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_ns
    $error("wb_xbar_decoder: NUM_SLAVES must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("wb_xbar_decoder: TIMEOUT_CYCLES must be 1..255");
  end

  logic [1:0]            state_q;
  logic [SW-1:0]         sel_q;
  logic                  err_q;
  logic                  shutdown_q;
  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES-1:0] win_oh;
  logic [SW-1:0]         win_idx;
  logic                  any_hit;
  logic                  shut_hit;
  logic                  win_stall;
  logic                  sel_ack;
  logic [31:0]           sel_data;

  // One comparator per slave window.
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_hit
    wb_xbar_hit #(
      .BASE (SLAVE_BASE[32*k +: 32]),
      .MASK (SLAVE_MASK[32*k +: 32])
    ) u_hit (
      .addr (bus.i_wb_addr),
      .hit  (hit[k])
    );
  end

  // The shutdown register shadows every slave window.
  assign shut_hit = (bus.i_wb_addr == SHUTDOWN_ADDR);

  // Priority pick: lowest-numbered matching slave wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_hit = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (!shut_hit && !any_hit && hit[k]) begin
        win_oh[k] = 1'b1;
        win_idx   = SW'(k);
        any_hit   = 1'b1;
      end
    end
  end

  assign win_stall = |(win_oh & bus.i_s_wb_stall);

  // Return-path mux for the slave owning the outstanding transaction.
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = 32'hFFFF_FFFF;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SW'(k)) begin
        sel_ack  = bus.i_s_wb_ack[k];
        sel_data = bus.i_s_wb_data[32*k +: 32];
      end
    end
  end

  // Request fields fan out unchanged to every slave.
  assign bus.o_s_wb_we   = bus.i_wb_we;
  assign bus.o_s_wb_addr = bus.i_wb_addr;
  assign bus.o_s_wb_data = bus.i_wb_data;
  assign bus.o_s_wb_sel  = bus.i_wb_sel;
  assign bus.o_shutdown  = shutdown_q;

  // Bus outputs per state; everything is held quiet while reset is asserted.
  always_comb begin
    bus.o_s_wb_stb = '0;
    bus.o_wb_ack   = 1'b0;
    bus.o_wb_err   = 1'b0;
    bus.o_wb_stall = 1'b0;
    bus.o_wb_data  = 32'hFFFF_FFFF;
    if (i_reset_n) begin
      case (state_q)
        S_IDLE: begin
          bus.o_s_wb_stb = bus.i_wb_stb ? win_oh : '0;
          bus.o_wb_stall = win_stall;
        end
        S_WAIT: begin
          bus.o_wb_stall = 1'b1;
          bus.o_wb_ack   = sel_ack;
          bus.o_wb_data  = sel_data;
        end
        S_RESP: begin
          bus.o_wb_stall = 1'b1;
          bus.o_wb_ack   = 1'b1;
          bus.o_wb_err   = err_q;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_XBAR_TIMEOUT_EN
  logic [7:0] cnt_q;
`endif

  // Transaction sequencer: accept, wait for the owning slave, or respond locally.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      err_q      <= 1'b0;
      shutdown_q <= 1'b0;
`ifdef WB_XBAR_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_wb_stb) begin
            if (shut_hit) begin
              state_q <= S_RESP;
              err_q   <= 1'b0;
              if (bus.i_wb_we && bus.i_wb_data == 32'h1) shutdown_q <= 1'b1;
            end else if (any_hit) begin
              if (!win_stall) begin
                sel_q   <= win_idx;
                state_q <= S_WAIT;
`ifdef WB_XBAR_TIMEOUT_EN
                cnt_q   <= '0;
`endif
              end
            end else begin
              state_q <= S_RESP;
              err_q   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (sel_ack) begin
            state_q <= S_IDLE;
          end
`ifdef WB_XBAR_TIMEOUT_EN
          // Last counted cycle without an ack: give up with an error.
          else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            state_q <= S_RESP;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_xbar_decoder.sv
// Self-checking bench for wb_xbar_decoder: directed vector table, hand-written
// corner sequences (stall, shutdown, reset mid-transaction, timeout when the
// WB_XBAR_TIMEOUT_EN macro is set) and randomized traffic against a model.
module tb_wb_xbar_decoder;
  localparam int NS = 4;
  localparam logic [NS*32-1:0] BASES = {32'h2000_0000, 32'hFFFF_FFF1, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFF00_0000, 32'hFFFF_FFFF, 32'hFFFF_F000, 32'hFFFF_0000};
  localparam logic [31:0] SHUT = 32'hFFFF_FFF2;
  localparam int KIND_UNMAP = -1;
  localparam int KIND_SHUT  = -2;

  logic i_clk = 1'b0;
  logic i_reset_n;
  int   n_chk = 0;
  int   n_fail = 0;
  logic model_shut = 1'b0;

  wb_xbar_decoder_if #(.NUM_SLAVES(NS)) bus ();

  wb_xbar_decoder #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(4)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          kind;    // slave index, KIND_UNMAP or KIND_SHUT
    int          delay;   // slave ack delay in WAIT cycles
    logic        shut;    // o_shutdown expected after the transaction
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference decode straight from the address map rules.
  function automatic int model_decode(input logic [31:0] a);
    if (a == SHUT) return KIND_SHUT;
    for (int k = 0; k < NS; k++)
      if ((a & MASKS[32*k +: 32]) == BASES[32*k +: 32]) return k;
    return KIND_UNMAP;
  endfunction

  // One full master transaction; starts and ends just after a rising edge.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int kind, input int stalls, input int delay, input bit spur);
    logic [31:0] rdata;
    logic [NS-1:0] oh;
    rdata = $urandom;
    for (int k = 0; k < NS; k++) bus.i_s_wb_data[32*k +: 32] = $urandom;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = addr;
    bus.i_wb_we   = we;
    bus.i_wb_data = wdata;
    bus.i_wb_sel  = 3'($urandom);
    if (kind >= 0) begin
      oh = NS'(1) << kind;
      for (int s = 0; s < stalls; s++) begin
        bus.i_s_wb_stall[kind] = 1'b1;
        @(negedge i_clk);
        chk("stall_out", 32'(bus.o_wb_stall), 32'd1);
        chk("stall_stb", 32'(bus.o_s_wb_stb), 32'(oh));
        chk("stall_ack", 32'(bus.o_wb_ack), 32'd0);
        step();
      end
      bus.i_s_wb_stall = '0;
      @(negedge i_clk);
      chk("req_stb", 32'(bus.o_s_wb_stb), 32'(oh));
      chk("req_stall", 32'(bus.o_wb_stall), 32'd0);
      chk("req_fwd", {bus.o_s_wb_addr[27:0], bus.o_s_wb_sel, bus.o_s_wb_we},
                     {addr[27:0], bus.i_wb_sel, we});
      chk("req_wdata", bus.o_s_wb_data, wdata);
      step();
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_addr = 32'h3000_0000;
      for (int d = 0; d < delay; d++) begin
        if (spur) bus.i_s_wb_ack[(kind + 1) % NS] = 1'b1;
        @(negedge i_clk);
        chk("wait_ack", 32'(bus.o_wb_ack), 32'd0);
        chk("wait_stall", 32'(bus.o_wb_stall), 32'd1);
        chk("wait_stb", 32'(bus.o_s_wb_stb), 32'd0);
        step();
        bus.i_s_wb_ack = '0;
      end
      bus.i_s_wb_ack[kind] = 1'b1;
      bus.i_s_wb_data[32*kind +: 32] = rdata;
      @(negedge i_clk);
      chk("ack", 32'(bus.o_wb_ack), 32'd1);
      chk("ack_err", 32'(bus.o_wb_err), 32'd0);
      chk("ack_data", bus.o_wb_data, rdata);
      step();
      bus.i_s_wb_ack = '0;
      @(negedge i_clk);
      chk("post_ack", 32'(bus.o_wb_ack), 32'd0);
      chk("post_stall", 32'(bus.o_wb_stall), 32'd0);
    end else begin
      @(negedge i_clk);
      chk("loc_stb", 32'(bus.o_s_wb_stb), 32'd0);
      chk("loc_ack0", 32'(bus.o_wb_ack), 32'd0);
      chk("loc_stall0", 32'(bus.o_wb_stall), 32'd0);
      step();
      if (kind == KIND_SHUT && we && wdata == 32'h1) model_shut = 1'b1;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_addr = 32'h3000_0000;
      @(negedge i_clk);
      chk("loc_ack", 32'(bus.o_wb_ack), 32'd1);
      chk("loc_err", 32'(bus.o_wb_err), 32'(kind == KIND_UNMAP));
      chk("loc_data", bus.o_wb_data, 32'hFFFF_FFFF);
      chk("loc_stall", 32'(bus.o_wb_stall), 32'd1);
      step();
      @(negedge i_clk);
      chk("loc_post_ack", 32'(bus.o_wb_ack), 32'd0);
    end
    chk("shutdown", 32'(bus.o_shutdown), 32'(model_shut));
    step();
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h0000_0010, 1'b0, 32'h0,        0,          2, 1'b0};
    vecs[1]  = '{32'h0000_FFFC, 1'b1, 32'h1234_5678, 0,         0, 1'b0};
    vecs[2]  = '{32'h0001_0000, 1'b0, 32'h0,        KIND_UNMAP, 0, 1'b0};
    vecs[3]  = '{32'h1000_0FFF, 1'b0, 32'h0,        1,          1, 1'b0};
    vecs[4]  = '{32'h1000_1000, 1'b0, 32'h0,        KIND_UNMAP, 0, 1'b0};
    vecs[5]  = '{32'hFFFF_FFF1, 1'b1, 32'hA5A5_5A5A, 2,         0, 1'b0};
    vecs[6]  = '{32'hFFFF_FFF0, 1'b0, 32'h0,        KIND_UNMAP, 0, 1'b0};
    vecs[7]  = '{32'h20AB_CDEF, 1'b0, 32'h0,        3,          2, 1'b0};
    vecs[8]  = '{32'h3000_0000, 1'b0, 32'h0,        KIND_UNMAP, 0, 1'b0};
    vecs[9]  = '{32'hFFFF_FFF2, 1'b0, 32'h1,        KIND_SHUT,  0, 1'b0};
    vecs[10] = '{32'hFFFF_FFF2, 1'b1, 32'h2,        KIND_SHUT,  0, 1'b0};
    vecs[11] = '{32'h2000_0000, 1'b1, 32'h1,        3,          0, 1'b0};

    i_reset_n        = 1'b0;
    bus.i_wb_stb     = 1'b1;
    bus.i_wb_we      = 1'b0;
    bus.i_wb_addr    = 32'h0000_0010;
    bus.i_wb_data    = '0;
    bus.i_wb_sel     = '0;
    bus.i_s_wb_data  = '0;
    bus.i_s_wb_ack   = '1;
    bus.i_s_wb_stall = '1;

    // Reset: outputs quiet even with a live strobe and slave acks.
    @(negedge i_clk);
    chk("rst_stb", 32'(bus.o_s_wb_stb), 32'd0);
    chk("rst_ack", 32'(bus.o_wb_ack), 32'd0);
    chk("rst_err", 32'(bus.o_wb_err), 32'd0);
    chk("rst_stall", 32'(bus.o_wb_stall), 32'd0);
    chk("rst_shut", 32'(bus.o_shutdown), 32'd0);
    step();
    bus.i_wb_stb     = 1'b0;
    bus.i_s_wb_ack   = '0;
    bus.i_s_wb_stall = '0;
    i_reset_n        = 1'b1;
    step();

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].kind, 0, vecs[i].delay, 1'b0);
      chk("vec_shut", 32'(bus.o_shutdown), 32'(vecs[i].shut));
    end

    // Slave2 stalls 3 cycles, slave3 acks spuriously during WAIT.
    do_txn(32'hFFFF_FFF1, 1'b0, 32'h0, 2, 3, 2, 1'b1);

    // Shutdown write, sticky over idle cycles and later writes.
    do_txn(SHUT, 1'b1, 32'h1, KIND_SHUT, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("shut_sticky", 32'(bus.o_shutdown), 32'd1);
      step();
    end
    do_txn(SHUT, 1'b1, 32'h0, KIND_SHUT, 0, 0, 1'b0);

`ifdef WB_XBAR_TIMEOUT_EN
    // Silent slave1: error ack after 4 WAIT cycles; a late ack is dropped.
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 32'h1000_0004;
    bus.i_wb_we   = 1'b0;
    @(negedge i_clk);
    chk("tmo_stb", 32'(bus.o_s_wb_stb), 32'h2);
    step();
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_addr = 32'h3000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("tmo_wait", 32'(bus.o_wb_ack), 32'd0);
      step();
    end
    @(negedge i_clk);
    chk("tmo_ack", 32'(bus.o_wb_ack), 32'd1);
    chk("tmo_err", 32'(bus.o_wb_err), 32'd1);
    chk("tmo_data", bus.o_wb_data, 32'hFFFF_FFFF);
    step();
    bus.i_s_wb_ack[1] = 1'b1;
    @(negedge i_clk);
    chk("tmo_late", 32'(bus.o_wb_ack), 32'd0);
    step();
    bus.i_s_wb_ack = '0;
`endif

    // Reset while waiting on slave0: transaction dropped with no ack.
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_addr = 32'h0000_0010;
    bus.i_wb_we   = 1'b0;
    @(negedge i_clk);
    chk("rw_stb", 32'(bus.o_s_wb_stb), 32'h1);
    step();
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_addr = 32'h3000_0000;
    @(negedge i_clk);
    chk("rw_wait", 32'(bus.o_wb_stall), 32'd1);
    step();
    i_reset_n         = 1'b0;
    bus.i_s_wb_ack[0] = 1'b1;
    model_shut        = 1'b0;
    @(negedge i_clk);
    chk("rw_ack", 32'(bus.o_wb_ack), 32'd0);
    chk("rw_stall", 32'(bus.o_wb_stall), 32'd0);
    chk("rw_shut", 32'(bus.o_shutdown), 32'd0);
    step();
    i_reset_n      = 1'b1;
    bus.i_s_wb_ack = '0;
    @(negedge i_clk);
    chk("rw_idle_ack", 32'(bus.o_wb_ack), 32'd0);
    chk("rw_idle_stall", 32'(bus.o_wb_stall), 32'd0);
    step();
    do_txn(32'h0000_0010, 1'b0, 32'h0, 0, 0, 2, 1'b0);

    // Randomized traffic against the model decode.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [31:0] wd;
      case ($urandom % 6)
        0: a = {16'h0000, 16'($urandom)};
        1: a = {20'h10000, 12'($urandom)};
        2: a = 32'hFFFF_FFF1;
        3: a = {8'h20, 24'($urandom)};
        4: a = SHUT;
        default: a = $urandom;
      endcase
      wd = ($urandom % 2 == 0) ? 32'h1 : $urandom;
      do_txn(a, 1'($urandom), wd, model_decode(a), $urandom % 3, $urandom % 3, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
